// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared types and helpers for the I-cache AXI refill engine.
//   refill_state_e  : FSM states IDLE / AR / R / RTRN
//   AXI_BURST_INCR  : AXI INCR burst encoding
//   num_beats()     : R beats per cache line
//   axi_size()      : AXI AxSIZE encoding for a data bus width
//   idx_width()     : word-index width, never below 1 bit
package icache_refill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RTRN = 2'd3
  } refill_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic int unsigned num_beats(input int unsigned line_w,
                                            input int unsigned data_w);
    return line_w / data_w;
  endfunction

  function automatic logic [2:0] axi_size(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_refill_linebuf.sv
// icache_refill_linebuf: line assembly buffer for the refill engine.
//   clk_i, rst_ni : clock, async active-low reset (buffer resets to 0)
//   clr_i         : synchronous clear of the whole line (wins over we_i)
//   we_i, idx_i   : write wdata_i into word idx_i
//   wdata_i       : one AXI data word
//   line_o        : flattened line, word 0 in the least significant bits
module icache_refill_linebuf
  import icache_refill_pkg::*;
#(
  parameter int unsigned LineWidth = 128,
  parameter int unsigned WordWidth = 64,
  parameter int unsigned IdxWidth  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  logic [IdxWidth-1:0]  idx_i,
  input  logic [WordWidth-1:0] wdata_i,
  output logic [LineWidth-1:0] line_o
);

  localparam int unsigned NumWords = num_beats(LineWidth, WordWidth);

  logic [NumWords-1:0][WordWidth-1:0] words_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q <= '0;
    end else if (clr_i) begin
      words_q <= '0;
    end else if (we_i) begin
      for (int i = 0; i < NumWords; i++) begin
        if (idx_i == IdxWidth'(i)) words_q[i] <= wdata_i;
      end
    end
  end

  assign line_o = words_q;

endmodule

// File: rtl/icache_axi_refill.sv
// icache_axi_refill: read-only AXI refill engine behind the L1 I-cache.
// One request at a time: grant in IDLE, one AR burst, collect R beats into
// the line buffer, then a single-cycle return pulse with the assembled line.
//   req_*  / gnt_o   : cache fetch request port (gnt_o = req_i while IDLE)
//   rtrn_*           : line return, no backpressure
//   ar_* / r_*       : AXI read address and read data channels
//   busy_o           : FSM not IDLE
// Optional: define ICACHE_REFILL_ERR_REPORT_EN to report SLVERR/DECERR and
// beat-count mismatches on rtrn_err_o; otherwise rtrn_err_o is tied 0.
module icache_axi_refill
  import icache_refill_pkg::*;
#(
  parameter int unsigned AddrWidth    = 56,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned TidWidth     = 2,
  parameter int unsigned RdTxId       = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [AddrWidth-1:0]    req_paddr_i,
  input  logic                    req_nc_i,
  input  logic [TidWidth-1:0]     req_tid_i,
  output logic                    rtrn_vld_o,
  output logic [LineWidth-1:0]    rtrn_data_o,
  output logic [TidWidth-1:0]     rtrn_tid_o,
  output logic                    rtrn_err_o,
  output logic                    busy_o,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [AxiAddrWidth-1:0] ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [1:0]              ar_burst_o,
  output logic [AxiIdWidth-1:0]   ar_id_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [AxiDataWidth-1:0] r_data_i,
  input  logic [1:0]              r_resp_i,
  input  logic                    r_last_i
);

  localparam int unsigned NumBeats = num_beats(LineWidth, AxiDataWidth);
  localparam int unsigned CntWidth = idx_width(NumBeats);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(NumBeats - 1);

  refill_state_e           state_q;
  logic                    ar_valid_q, r_ready_q, rtrn_vld_q, busy_q;
  logic [AxiAddrWidth-1:0] ar_addr_q;
  logic [7:0]              ar_len_q;
  logic [TidWidth-1:0]     tid_q;
  logic [CntWidth-1:0]     cnt_q;

  logic                    grant, beat;
  logic [AxiAddrWidth-1:0] paddr_ext, line_addr, word_addr;

  assign grant = (state_q == IDLE) && req_i;
  assign beat  = r_ready_q && r_valid_i;

  assign paddr_ext = AxiAddrWidth'(req_paddr_i);
  assign line_addr = paddr_ext & ~AxiAddrWidth'(LineWidth / 8 - 1);
  assign word_addr = paddr_ext & ~AxiAddrWidth'(AxiDataWidth / 8 - 1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      rtrn_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      tid_q      <= '0;
      cnt_q      <= '0;
    end else begin
      rtrn_vld_q <= 1'b0;
      case (state_q)
        IDLE: if (req_i) begin
          state_q    <= AR;
          ar_valid_q <= 1'b1;
          busy_q     <= 1'b1;
          ar_addr_q  <= req_nc_i ? word_addr : line_addr;
          ar_len_q   <= req_nc_i ? 8'd0 : 8'(NumBeats - 1);
          tid_q      <= req_tid_i;
          cnt_q      <= '0;
        end
        AR: if (ar_ready_i) begin
          state_q    <= R;
          ar_valid_q <= 1'b0;
          r_ready_q  <= 1'b1;
        end
        R: if (r_valid_i) begin
          // Saturate so surplus beats keep landing in the last word.
          if (cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
          if (r_last_i) begin
            state_q    <= RTRN;
            r_ready_q  <= 1'b0;
            rtrn_vld_q <= 1'b1;
          end
        end
        RTRN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  icache_refill_linebuf #(
    .LineWidth(LineWidth),
    .WordWidth(AxiDataWidth),
    .IdxWidth (CntWidth)
  ) u_linebuf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (grant),
    .we_i   (beat),
    .idx_i  (cnt_q),
    .wdata_i(r_data_i),
    .line_o (rtrn_data_o)
  );

`ifdef ICACHE_REFILL_ERR_REPORT_EN
  logic       err_q;
  logic [7:0] beat_idx_q;

  // beat_idx_q counts every accepted beat (unlike cnt_q) so that both
  // short and over-long bursts are caught against ar_len_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q      <= 1'b0;
      beat_idx_q <= '0;
    end else if (grant) begin
      err_q      <= 1'b0;
      beat_idx_q <= '0;
    end else if (beat) begin
      if (r_resp_i[1] || (r_last_i && (beat_idx_q != ar_len_q))) err_q <= 1'b1;
      if (beat_idx_q != 8'hff) beat_idx_q <= beat_idx_q + 8'd1;
    end
  end

  assign rtrn_err_o = rtrn_vld_q && err_q;
`else
  assign rtrn_err_o = 1'b0;
`endif

  logic unused_resp;
  assign unused_resp = ^r_resp_i;

  assign gnt_o      = grant;
  assign rtrn_vld_o = rtrn_vld_q;
  assign rtrn_tid_o = tid_q;
  assign busy_o     = busy_q;
  assign ar_valid_o = ar_valid_q;
  assign ar_addr_o  = ar_addr_q;
  assign ar_len_o   = ar_len_q;
  // Constant AR fields are only driven while a request is presented.
  assign ar_size_o  = ar_valid_q ? axi_size(AxiDataWidth) : 3'd0;
  assign ar_burst_o = ar_valid_q ? AXI_BURST_INCR : 2'b00;
  assign ar_id_o    = ar_valid_q ? AxiIdWidth'(RdTxId) : '0;
  assign r_ready_o  = r_ready_q;

endmodule
